dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of both master ports and the synchronous RAM port of the data-memory arbiter.
// The slave modport is the arbiter view; the master modport is the environment view.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                    m0_req;
  logic                    m0_we;
  logic [ADDR_WIDTH-1:0]   m0_addr;
  logic [DATA_WIDTH-1:0]   m0_wdata;
  logic [STRB_WIDTH-1:0]   m0_wstrb;
  logic                    m0_gnt;
  logic                    m0_rsp_valid;
  logic [DATA_WIDTH-1:0]   m0_rsp_rdata;
  logic                    m0_rsp_err;

  logic                    m1_req;
  logic                    m1_we;
  logic [ADDR_WIDTH-1:0]   m1_addr;
  logic [DATA_WIDTH-1:0]   m1_wdata;
  logic [STRB_WIDTH-1:0]   m1_wstrb;
  logic                    m1_gnt;
  logic                    m1_rsp_valid;
  logic [DATA_WIDTH-1:0]   m1_rsp_rdata;
  logic                    m1_rsp_err;

  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-3:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [STRB_WIDTH-1:0]   mem_wstrb;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m0_gnt, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m1_gnt, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m0_gnt, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m1_gnt, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous data RAM.
// Grants and the RAM request are combinational; responses come from registered state one cycle later.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic          GLOBAL_CLK_IN,
  input  logic          GLOBAL_RST_N,
  dmem_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    PRIO_M0 = 1'b0,
    PRIO_M1 = 1'b1
  } prio_e;

  function automatic logic f_is_aligned(input logic [ADDR_WIDTH-1:0] addr);
    f_is_aligned = (addr[1:0] == 2'b00);
  endfunction

  prio_e                 r_prio;
  logic                  r_rsp_pending;
  logic                  r_rsp_owner;
  logic                  r_rsp_is_read;
  logic                  r_rsp_err;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any_gnt;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [STRB_WIDTH-1:0] w_sel_wstrb;
  logic                  w_aligned;
  logic                  w_mem_en;
  logic                  w_m0_rsp_valid;
  logic                  w_m1_rsp_valid;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;

  // Grant decision: a lone requester always wins, a tie goes to the favoured master.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (GLOBAL_RST_N) begin
      case ({bus.m1_req, bus.m0_req})
        2'b01: w_gnt0 = 1'b1;
        2'b10: w_gnt1 = 1'b1;
        2'b11: begin
          if (r_prio == PRIO_M1) begin
            w_gnt1 = 1'b1;
          end else begin
            w_gnt0 = 1'b1;
          end
        end
        default: begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
        end
      endcase
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;

  // Request mux: the granted master's fields are steered to the RAM port.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    if (w_gnt1) begin
      w_sel_we    = bus.m1_we;
      w_sel_addr  = bus.m1_addr;
      w_sel_wdata = bus.m1_wdata;
      w_sel_wstrb = bus.m1_wstrb;
    end else begin
      w_sel_we    = bus.m0_we;
      w_sel_addr  = bus.m0_addr;
      w_sel_wdata = bus.m0_wdata;
      w_sel_wstrb = bus.m0_wstrb;
    end
  end

  assign w_aligned = f_is_aligned(w_sel_addr);
  // A misaligned grant is still accepted but never reaches the RAM.
  assign w_mem_en  = w_any_gnt & w_aligned;

  assign bus.m0_gnt    = w_gnt0;
  assign bus.m1_gnt    = w_gnt1;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_en & w_sel_we;
  assign bus.mem_addr  = w_sel_addr[ADDR_WIDTH-1:2];
  assign bus.mem_wdata = w_sel_wdata;
  assign bus.mem_wstrb = w_mem_en ? w_sel_wstrb : {STRB_WIDTH{1'b0}};

  // Priority FSM and response tracking; reset drops any response still in flight.
  always_ff @(posedge GLOBAL_CLK_IN or negedge GLOBAL_RST_N) begin
    if (!GLOBAL_RST_N) begin
      r_prio        <= PRIO_M0;
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= 1'b0;
      r_rsp_is_read <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_rsp_pending <= w_any_gnt;
      if (w_any_gnt) begin
        r_rsp_owner   <= w_gnt1;
        r_rsp_is_read <= w_aligned & ~w_sel_we;
        r_rsp_err     <= ~w_aligned;
        case (r_prio)
          PRIO_M0: r_prio <= w_gnt0 ? PRIO_M1 : PRIO_M0;
          PRIO_M1: r_prio <= w_gnt1 ? PRIO_M0 : PRIO_M1;
          default: r_prio <= PRIO_M0;
        endcase
      end else begin
        r_rsp_owner   <= r_rsp_owner;
        r_rsp_is_read <= r_rsp_is_read;
        r_rsp_err     <= r_rsp_err;
        r_prio        <= r_prio;
      end
    end
  end

  // RAM read data arrives in the response cycle, so it is passed through only for read responses.
  always_comb begin
    w_m0_rsp_valid = r_rsp_pending & ~r_rsp_owner;
    w_m1_rsp_valid = r_rsp_pending &  r_rsp_owner;
    w_rsp_rdata    = '0;
    if (r_rsp_pending && r_rsp_is_read) begin
      w_rsp_rdata = bus.mem_rdata;
    end else begin
      w_rsp_rdata = '0;
    end
  end

  assign bus.m0_rsp_valid = w_m0_rsp_valid;
  assign bus.m0_rsp_rdata = w_m0_rsp_valid ? w_rsp_rdata : {DATA_WIDTH{1'b0}};
  assign bus.m0_rsp_err   = w_m0_rsp_valid & r_rsp_err;
  assign bus.m1_rsp_valid = w_m1_rsp_valid;
  assign bus.m1_rsp_rdata = w_m1_rsp_valid ? w_rsp_rdata : {DATA_WIDTH{1'b0}};
  assign bus.m1_rsp_err   = w_m1_rsp_valid & r_rsp_err;
endmodule
